// File: rtl/spi_load_slave.sv
// spi_load_slave
// ---------------------------------------------------------------------------
// SPI mode-0 slave that decodes the flash-load byte stream into 32-bit memory
// writes on a valid/ready bus. The pad signals are synchronized into i_clk,
// assembled into bytes, and fed to a small command FSM:
//   0x01 + 4 address bytes (MSB first) -> load write address
//   0x02 + 4 data bytes    (MSB first) -> issue one write, address auto-steps
//   anything else                      -> skip bytes until chip select rises
//
// Ports
//   i_clk, i_rst      system clock, synchronous active-high reset
//   i_sclk, i_cs_n,   SPI pads, asynchronous to i_clk
//   i_mosi
//   o_miso            status byte {6'b0, o_wr_valid, o_overflow}, MSB first
//   o_wr_valid        write request pending
//   i_wr_ready        downstream takes the write when high with o_wr_valid
//   o_wr_addr         write byte address
//   o_wr_data         write data
//   o_overflow        sticky: a completed data word was dropped
//
// Handshake: o_wr_valid, once raised, stays high with o_wr_addr/o_wr_data
// stable until a cycle in which i_wr_ready is also high; that cycle is the
// transfer, and o_wr_valid drops on the following cycle unless a new word
// completes in that same cycle.
// ---------------------------------------------------------------------------
module spi_load_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned ADDR_INC    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sclk,
  input  logic        i_cs_n,
  input  logic        i_mosi,
  output logic        o_miso,
  output logic        o_wr_valid,
  input  logic        i_wr_ready,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_SKIP = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Pad synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_prev_q, cs_prev_q;
  logic rise_q, fall_q, cs_rise_q, mosi_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;   // deselected
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // mosi_q is registered alongside rise_q so the sampled bit lines up with
  // the rising-edge strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      cs_rise_q   <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      rise_q      <= sclk_s & ~sclk_prev_q & ~cs_s;
      fall_q      <= ~sclk_s & sclk_prev_q & ~cs_s;
      cs_rise_q   <= cs_s & ~cs_prev_q;
      mosi_q      <= mosi_s;
    end
  end

  // ---------------------------------------------------------------------
  // Byte assembler. The completed byte is read from rx_sh_q while
  // byte_stb_q is high (one cycle after the 8th rising-edge strobe).
  // ---------------------------------------------------------------------
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_sh_q;
  logic       byte_stb_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt_q  <= 3'd0;
      rx_sh_q    <= 8'h00;
      byte_stb_q <= 1'b0;
    end else begin
      byte_stb_q <= 1'b0;
      if (cs_s) begin
        bit_cnt_q <= 3'd0;   // deselect drops any partial byte
      end else if (rise_q) begin
        rx_sh_q   <= {rx_sh_q[6:0], mosi_q};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_stb_q <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Command FSM and write port
  // ---------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] addr_sh_q, addr_sh_d;
  // Only the first three data bytes are held; the fourth completes the
  // word directly into o_wr_data.
  logic [23:0] data_sh_q, data_sh_d;
  logic        addr_pend_q, addr_pend_d;
  logic        wr_valid_q, wr_valid_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        overflow_q, overflow_d;
  logic        accept;
  logic        can_take;

  assign accept   = wr_valid_q & i_wr_ready;
  // The write slot is free if nothing is pending or it empties this cycle.
  assign can_take = ~wr_valid_q | accept;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      addr_sh_q   <= 32'h0;
      data_sh_q   <= 24'h0;
      addr_pend_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 32'h0;
      wr_data_q   <= 32'h0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      addr_pend_q <= addr_pend_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    addr_pend_d = addr_pend_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    overflow_d  = overflow_q;

    // Transfer: a deferred address load wins over the auto-increment.
    if (accept) begin
      wr_valid_d = 1'b0;
      if (addr_pend_q) begin
        wr_addr_d   = addr_sh_q;
        addr_pend_d = 1'b0;
      end else begin
        wr_addr_d = wr_addr_q + 32'(ADDR_INC);
      end
    end

    if (state_q == ST_SKIP && cs_rise_q) begin
      state_d = ST_IDLE;
    end

    if (byte_stb_q) begin
      case (state_q)
        ST_IDLE: begin
          idx_d = 2'd0;
          case (rx_sh_q)
            8'h01:   state_d = ST_ADDR;
            8'h02:   state_d = ST_DATA;
            default: state_d = ST_SKIP;
          endcase
        end
        ST_ADDR: begin
          addr_sh_d = {addr_sh_q[23:0], rx_sh_q};
          idx_d     = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
            if (can_take) begin
              wr_addr_d   = addr_sh_d;
              addr_pend_d = 1'b0;
            end else begin
              addr_pend_d = 1'b1;   // load once the pending write drains
            end
          end
        end
        ST_DATA: begin
          data_sh_d = {data_sh_q[15:0], rx_sh_q};
          idx_d     = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
            if (can_take) begin
              wr_data_d  = {data_sh_q, rx_sh_q};
              wr_valid_d = 1'b1;
            end else begin
              overflow_d = 1'b1;    // new word dropped, pending one kept
            end
          end
        end
        default: ;                  // ST_SKIP: bytes ignored
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // MISO status shifter. Reloaded continuously between bytes so bit 7 is
  // on the pin before the first rising edge of each byte.
  // ---------------------------------------------------------------------
  logic [7:0] tx_sh_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_sh_q <= 8'h00;
    end else if (bit_cnt_q == 3'd0) begin
      tx_sh_q <= {6'b0, wr_valid_q, overflow_q};
    end else if (fall_q) begin
      tx_sh_q <= {tx_sh_q[6:0], 1'b0};
    end
  end

  assign o_miso     = ~cs_s & tx_sh_q[7];
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_overflow = overflow_q;

endmodule
